// File: rtl/alu_exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_pkg
// Description : Shared definitions for the ALU execute stage: ALU select
//               codes and the packed result record carried through the
//               result queue.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_exec_pkg;

    // ALU select codes understood by Alu (ALU_Sel)
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef struct packed {
        logic [31:0] result;
        logic        carry;
        logic        zero;
        logic [3:0]  tag;
    } alu_result_t;

    function automatic alu_result_t pack_result(
        input logic [31:0] result,
        input logic        carry,
        input logic        zero,
        input logic [3:0]  tag
    );
        alu_result_t r;
        r.result = result;
        r.carry  = carry;
        r.zero   = zero;
        r.tag    = tag;
        return r;
    endfunction

endpackage : alu_exec_pkg
`default_nettype wire

// File: rtl/Alu.sv
`default_nettype none
// ============================================================================
// Module      : Alu
// Description : 32-bit combinational ALU.
//   A, B     : operands
//   ALU_Sel  : operation select (codes in alu_exec_pkg)
//   ALU_Out  : result
//   coutfin  : carry out (ADD) / no-borrow (SUB); 0 for other operations
//   z        : result is zero
// Revision    : 1.0 - initial release
// ============================================================================
module Alu
    import alu_exec_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  ALU_Sel,
    output logic [31:0] ALU_Out,
    output logic        coutfin,
    output logic        z
);

    logic [32:0] w_sum;
    logic [32:0] w_diff;

    assign w_sum  = {1'b0, A} + {1'b0, B};
    // Subtract as A + ~B + 1 so bit 32 is the no-borrow carry
    assign w_diff = {1'b0, A} + {1'b0, ~B} + 33'd1;

    always_comb begin
        ALU_Out = 32'd0;
        coutfin = 1'b0;
        case (ALU_Sel)
            ALU_AND: ALU_Out = A & B;
            ALU_OR:  ALU_Out = A | B;
            ALU_XOR: ALU_Out = A ^ B;
            ALU_NOR: ALU_Out = ~(A | B);
            ALU_ADD: begin
                ALU_Out = w_sum[31:0];
                coutfin = w_sum[32];
            end
            ALU_SUB: begin
                ALU_Out = w_diff[31:0];
                coutfin = w_diff[32];
            end
            ALU_SLT: ALU_Out = {31'd0, ($signed(A) < $signed(B))};
            default: ALU_Out = 32'd0;
        endcase
    end

    assign z = (ALU_Out == 32'd0);

endmodule : Alu
`default_nettype wire

// File: rtl/alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_fifo
// Description : Small circular queue of alu_result_t with a registered head.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_data (ignored when full without a pop)
//   i_data     : entry to write
//   i_pop      : discard head (ignored when empty)
//   i_flush    : empty the queue, highest priority
//   o_count    : current occupancy
//   o_valid    : head valid
//   o_head     : head entry, all zero when empty
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_fifo
    import alu_exec_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  alu_result_t      i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [CNT_W-1:0] o_count,
    output logic             o_valid,
    output alu_result_t      o_head
);

    alu_result_t      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_rd_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    alu_result_t      r_head;
    alu_result_t      w_head_nxt;
    logic             w_push;
    logic             w_pop;

    assign w_pop       = i_pop && (r_count != '0) && !i_flush;
    assign w_push      = i_push && !i_flush && ((r_count < CNT_W'(DEPTH)) || w_pop);
    assign w_rd_nxt    = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // The head register tracks whatever entry will sit at the read pointer
    // after this edge. When the queue is (or becomes) otherwise empty the
    // pushed entry bypasses straight into the head because its memory slot
    // is only written at this same edge.
    always_comb begin
        w_head_nxt = r_head;
        if (i_flush || (w_count_nxt == '0)) begin
            w_head_nxt = '0;
        end else if ((r_count == '0) || (w_pop && (r_count == CNT_W'(1)))) begin
            w_head_nxt = i_data;
        end else if (w_pop) begin
            w_head_nxt = r_mem[w_rd_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_count_nxt;
            r_head   <= w_head_nxt;
        end
    end

    assign o_count = r_count;
    assign o_valid = (r_count != '0);
    assign o_head  = r_head;

endmodule : alu_result_fifo
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_stage
// Description : Execute stage around Alu. Operations enter over a
//               valid/ready handshake into an operand register that feeds
//               Alu; results are queued and leave, tagged, over a second
//               valid/ready handshake. Keeps a retired-operation counter
//               and a sticky carry flag.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : operation handshake
//   in_a, in_b, in_sel    : operands and ALU select
//   in_tag                : opaque tag returned with the result
//   out_valid/out_ready   : result handshake
//   out_result/carry/zero : head result fields (zero when empty)
//   out_tag               : head tag
//   flush                 : synchronous discard of all in-flight work
//   op_count              : retired results, wraps
//   sticky_carry          : set by any retired result with carry
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_stage
    import alu_exec_pkg::*;
#(
    parameter int OUT_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [3:0]       in_sel,
    input  logic [3:0]       in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic [3:0]       out_tag,
    input  logic             flush,
    output logic [CNT_W-1:0] op_count,
    output logic             sticky_carry
);

    localparam int QCNT_W = $clog2(OUT_DEPTH) + 1;

    logic              r_op_valid;
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic [3:0]        r_sel;
    logic [3:0]        r_tag;
    logic [CNT_W-1:0]  r_op_count;
    logic              r_sticky;

    logic [31:0]       w_alu_out;
    logic              w_alu_cout;
    logic              w_alu_z;
    logic [QCNT_W-1:0] w_qcount;
    logic              w_qvalid;
    alu_result_t       w_head;
    logic              w_pop_req;
    logic              w_drain;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;

    Alu u_alu (
        .A       (r_a),
        .B       (r_b),
        .ALU_Sel (r_sel),
        .ALU_Out (w_alu_out),
        .coutfin (w_alu_cout),
        .z       (w_alu_z)
    );

    // A full queue still accepts a push when its head leaves this cycle,
    // which is what lets the stage sustain one op per cycle.
    assign w_pop_req = w_qvalid && out_ready;
    assign w_drain   = r_op_valid && ((w_qcount < QCNT_W'(OUT_DEPTH)) || w_pop_req);
    // rst_n is folded in so the stage never advertises space during reset.
    assign in_ready  = rst_n && !flush && (!r_op_valid || w_drain);
    assign w_accept  = in_valid && in_ready;
    assign w_push    = w_drain && !flush;
    assign w_pop     = w_pop_req && !flush;

    alu_result_fifo #(
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (pack_result(w_alu_out, w_alu_cout, w_alu_z, r_tag)),
        .i_pop   (w_pop),
        .i_flush (flush),
        .o_count (w_qcount),
        .o_valid (w_qvalid),
        .o_head  (w_head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_valid <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_sel      <= '0;
            r_tag      <= '0;
        end else if (flush) begin
            r_op_valid <= 1'b0;
        end else if (w_accept) begin
            r_op_valid <= 1'b1;
            r_a        <= in_a;
            r_b        <= in_b;
            r_sel      <= in_sel;
            r_tag      <= in_tag;
        end else if (w_drain) begin
            r_op_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
            r_sticky   <= 1'b0;
        end else if (flush) begin
            r_sticky   <= 1'b0;
        end else if (w_pop) begin
            r_op_count <= r_op_count + CNT_W'(1);
            r_sticky   <= r_sticky | w_head.carry;
        end
    end

    assign out_valid    = w_qvalid;
    assign out_result   = w_head.result;
    assign out_carry    = w_head.carry;
    assign out_zero     = w_head.zero;
    assign out_tag      = w_head.tag;
    assign op_count     = r_op_count;
    assign sticky_carry = r_sticky;

endmodule : alu_exec_stage
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_stage
// Description : Self-checking bench for alu_exec_stage. Directed scenarios
//               plus randomized traffic, compared against an in-order
//               transaction model of the stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_stage;
    import alu_exec_pkg::*;

    localparam int D  = 2;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_a = '0;
    logic [31:0]   in_b = '0;
    logic [3:0]    in_sel = '0;
    logic [3:0]    in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_result;
    logic          out_carry;
    logic          out_zero;
    logic [3:0]    out_tag;
    logic          flush = 1'b0;
    logic [CW-1:0] op_count;
    logic          sticky_carry;

    always #5 clk = ~clk;

    alu_exec_stage #(.OUT_DEPTH(D), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_carry(out_carry), .out_zero(out_zero),
        .out_tag(out_tag), .flush(flush),
        .op_count(op_count), .sticky_carry(sticky_carry)
    );

    // Model: every accepted op is an entry in issue order, stamped with the
    // edge index at which it was accepted.
    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        z;
        logic [3:0]  tag;
        int          e;
    } exp_t;

    exp_t          q[$];
    int            m_edge = 0;
    logic [CW-1:0] m_cnt = '0;
    logic          m_sticky = 1'b0;
    logic [3:0]    dut_ret[$];
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic exp_t ref_alu(input logic [31:0] a, input logic [31:0] b,
                                     input logic [3:0] sel, input logic [3:0] tag);
        exp_t          r;
        longint unsigned s;
        r.res = 32'd0;
        r.c   = 1'b0;
        r.tag = tag;
        r.e   = 0;
        case (sel)
            ALU_AND: r.res = a & b;
            ALU_OR:  r.res = a | b;
            ALU_XOR: r.res = a ^ b;
            ALU_NOR: r.res = ~(a | b);
            ALU_ADD: begin
                s     = longint'(a) + longint'(b);
                r.res = s[31:0];
                r.c   = (s > 64'h0000_0000_FFFF_FFFF);
            end
            ALU_SUB: begin
                r.res = a - b;
                r.c   = (a >= b);
            end
            ALU_SLT: r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r.res = 32'd0;
        endcase
        r.z = (r.res == 32'd0);
        return r;
    endfunction

    // Head becomes visible one edge after the op was accepted.
    function automatic bit m_out_valid();
        return (q.size() > 0) && (q[0].e < m_edge);
    endfunction

    function automatic bit m_in_ready();
        if (flush) return 1'b0;
        return (q.size() < D + 1) || (m_out_valid() && out_ready);
    endfunction

    task automatic tick();
        exp_t h;
        bit   pop;
        bit   acc;
        #1;
        chk("in_ready", in_ready, m_in_ready());
        if (out_valid && out_ready && !flush) dut_ret.push_back(out_tag);
        @(posedge clk);
        if (flush) begin
            q.delete();
            m_sticky = 1'b0;
        end else begin
            pop = m_out_valid() && out_ready;
            acc = in_valid && m_in_ready();
            if (pop) begin
                h = q.pop_front();
                m_cnt++;
                m_sticky |= h.c;
            end
            if (acc) begin
                h   = ref_alu(in_a, in_b, in_sel, in_tag);
                h.e = m_edge + 1;
                q.push_back(h);
            end
        end
        m_edge++;
        @(negedge clk);
        chk("out_valid", out_valid, m_out_valid());
        if (m_out_valid()) begin
            chk("out_result", out_result, q[0].res);
            chk("out_carry", out_carry, q[0].c);
            chk("out_zero", out_zero, q[0].z);
            chk("out_tag", out_tag, q[0].tag);
        end else begin
            chk("empty_result", out_result, 32'd0);
            chk("empty_flags", {out_carry, out_zero, out_tag}, 6'd0);
        end
        chk("op_count", op_count, m_cnt);
        chk("sticky", sticky_carry, m_sticky);
    endtask

    // Called in the low clock phase; asserts reset between edges.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        flush = 1'b0;
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_flags", {out_carry, out_zero, out_tag}, 6'd0);
        chk("rst_count", op_count, 32'd0);
        chk("rst_sticky", sticky_carry, 1'b0);
        chk("rst_ready", in_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready_held", in_ready, 1'b0);
        rst_n = 1'b1;
        q.delete();
        m_cnt    = '0;
        m_sticky = 1'b0;
        m_edge   = 0;
        #1;
        chk("rel_ready", in_ready, 1'b1);
        chk("rel_count", op_count, 32'd0);
    endtask

    task automatic set_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] sel, input logic [3:0] tag);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sel   = sel;
        in_tag   = tag;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
    endtask

    logic [3:0]    sel_tab [8];
    logic [CW-1:0] cnt_save;

    initial begin
        sel_tab[0] = ALU_AND; sel_tab[1] = ALU_OR;  sel_tab[2] = ALU_ADD;
        sel_tab[3] = ALU_XOR; sel_tab[4] = ALU_SUB; sel_tab[5] = ALU_SLT;
        sel_tab[6] = ALU_NOR; sel_tab[7] = 4'b1111;

        @(negedge clk);
        do_reset();

        // Single op
        out_ready = 1'b1;
        set_op(32'hABCDEFFF, 32'h12345678, ALU_ADD, 4'd3);
        tick();
        in_valid = 1'b0;
        chk("single_lat1", out_valid, 1'b0);
        tick();
        chk("single_valid", out_valid, 1'b1);
        chk("single_res", out_result, 32'hBE024677);
        chk("single_cz", {out_carry, out_zero}, 2'b00);
        chk("single_tag", out_tag, 4'd3);
        tick();
        chk("single_cnt", op_count, 32'd1);

        // Zero / carry
        set_op(32'hFFFFFFFF, 32'h00000001, ALU_ADD, 4'd5);
        tick();
        in_valid = 1'b0;
        tick();
        chk("zc_res", out_result, 32'd0);
        chk("zc_cz", {out_carry, out_zero}, 2'b11);
        chk("zc_sticky_pre", sticky_carry, 1'b0);
        tick();
        chk("zc_sticky", sticky_carry, 1'b1);
        drain();

        // Backpressure
        out_ready = 1'b0;
        dut_ret.delete();
        for (int t = 0; t < 4; t++) begin
            set_op($urandom, $urandom, ALU_ADD, 4'(t));
            #1;
            chk("bp_ready", in_ready, (t < 3) ? 1'b1 : 1'b0);
            tick();
        end
        repeat (2) tick();
        out_ready = 1'b1;
        #1;
        chk("bp_resume", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        chk("bp_nret", dut_ret.size(), 4);
        for (int i = 0; i < 4 && i < dut_ret.size(); i++)
            chk("bp_order", dut_ret[i], 4'(i));

        // Full queue, simultaneous push and pop
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_op($urandom, $urandom, ALU_SUB, 4'(8 + i));
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_op($urandom, $urandom, ALU_XOR, 4'(i));
            #1;
            chk("full_acc", in_ready, 1'b1);
            chk("full_ret", out_valid, 1'b1);
            tick();
        end
        drain();

        // Flush with 2 queued + 1 in operand register
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_op($urandom, $urandom, ALU_OR, 4'(i));
            tick();
        end
        in_valid = 1'b0;
        chk("pre_flush_valid", out_valid, 1'b1);
        chk("pre_flush_sticky", sticky_carry, 1'b1);
        cnt_save = m_cnt;
        flush = 1'b1;
        set_op(32'h1, 32'h1, ALU_ADD, 4'd7);
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_sticky", sticky_carry, 1'b0);
        chk("flush_cnt", op_count, cnt_save);
        set_op(32'd5, 32'd7, ALU_ADD, 4'd9);
        tick();
        in_valid = 1'b0;
        tick();
        chk("fresh_res", out_result, 32'd12);
        chk("fresh_tag", out_tag, 4'd9);
        drain();

        // Randomized traffic with one asynchronous reset mid-stream
        for (int n = 0; n < 1500; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 39) == 0);
            in_sel    = sel_tab[$urandom_range(0, 7)];
            in_a      = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
            in_b      = ($urandom_range(0, 7) == 0) ? in_a : $urandom;
            in_tag    = 4'($urandom);
            if (n == 700) begin
                do_reset();
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_alu_exec_stage
`default_nettype wire
